us_timebase_multi: RTL



---
 rtl/us_timebase_pkg.sv | 8 +
 rtl/us_timebase_chan.sv | 62 ++++++
 rtl/us_timebase_multi.sv | 121 ++++++++++++
 3 files changed

// File: rtl/us_timebase_pkg.sv
// Shared register map and CTRL field layout for the multi-channel microsecond timebase.
package us_timebase_pkg;
   localparam logic [2:0] ADR_PER0 = 3'd0;
   localparam logic [2:0] ADR_CTRL = 3'd7;
   localparam int         EN_LSB   = 0;
   localparam int         OS_LSB   = 8;
   localparam int         MAX_NCH  = 6;
endpackage

// File: rtl/us_timebase_chan.sv
// One programmable channel: counts t1us strobes up to a period, pulse registered one clock after terminal count.
// Periodic or one-shot; a restart (load or enable rising edge) always beats a coincident terminal count.
module us_timebase_chan
   import us_timebase_pkg::*;
#(
   parameter int PW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [PW-1:0] per_i,
   input  logic          mode_i,
   input  logic          t1us_i,
   input  logic          load_i,
   input  logic          en_wr_i,
   input  logic          en_i,
   output logic          pulse_o,
   output logic          run_o
);
   logic [PW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic          pulse_q, pulse_d;

   always_comb begin
      cnt_d   = cnt_q;
      run_d   = run_q;
      pulse_d = 1'b0;
      if (en_wr_i) begin
         run_d = en_i;
      end
      // run_d already reflects a same-cycle disable, so that write suppresses the pulse.
      if (load_i || (en_wr_i && en_i && !run_q)) begin
         cnt_d = '0;
      end else if (t1us_i && run_d) begin
         if (per_i == '0) begin
            cnt_d = '0;
         end else if (cnt_q == per_i - PW'(1)) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
            if (mode_i) begin
               run_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         run_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;
   assign run_o   = run_q;
endmodule

// File: rtl/us_timebase_multi.sv
// Exact 1 us strobe prescaler, register file and NCH channel timers; rdata is registered one clock after adr.
// Define US_TIMEBASE_SYNC_IN_EN to add sync_in, which realigns the prescaler and all channel phases.
module us_timebase_multi
   import us_timebase_pkg::*;
#(
   parameter int CLK_DIV = 5,
   parameter int NCH     = 4,
   parameter int PW      = 16
) (
   input  logic           clk5mhz,
   input  logic           rst,
   input  logic           wr,
   input  logic [2:0]     adr,
   input  logic [15:0]    data,
   output logic [15:0]    rdata,
   output logic           t1us,
   output logic [NCH-1:0] ch_pulse,
   output logic [NCH-1:0] ch_run
`ifdef US_TIMEBASE_SYNC_IN_EN
   ,
   input  logic           sync_in
`endif
);
   localparam int PCW = $clog2(CLK_DIV);

   logic [PCW-1:0]     pcnt_q, pcnt_d;
   logic               t1us_q, t1us_d;
   logic [PW-1:0]      per_q [NCH];
   logic [PW-1:0]      per_d [NCH];
   logic [NCH-1:0]     os_q, os_d;
   logic [15:0]        rdata_q, rdata_d;
   logic [NCH-1:0]     per_wr;
   logic [MAX_NCH-1:0] run_pad, os_pad;
   logic               ctrl_wr;
   logic               sync;

`ifdef US_TIMEBASE_SYNC_IN_EN
   assign sync = sync_in;
`else
   assign sync = 1'b0;
`endif

   assign ctrl_wr = wr && (adr == ADR_CTRL);

   always_comb begin
      pcnt_d = pcnt_q + PCW'(1);
      t1us_d = 1'b0;
      if (sync) begin
         pcnt_d = '0;
      end else if (pcnt_q == PCW'(CLK_DIV - 1)) begin
         pcnt_d = '0;
         t1us_d = 1'b1;
      end
   end

   always_comb begin
      os_d = os_q;
      if (ctrl_wr) begin
         os_d = data[OS_LSB +: NCH];
      end
      for (int i = 0; i < NCH; i++) begin
         per_wr[i] = wr && (adr == ADR_PER0 + 3'(i));
         per_d[i]  = per_wr[i] ? data[PW-1:0] : per_q[i];
      end
   end

   // CTRL readback shows the live run state, so a finished one-shot reads as disabled.
   assign run_pad = MAX_NCH'(ch_run);
   assign os_pad  = MAX_NCH'(os_q);

   always_comb begin
      rdata_d = '0;
      if (adr == ADR_CTRL) begin
         rdata_d[EN_LSB +: MAX_NCH] = run_pad;
         rdata_d[OS_LSB +: MAX_NCH] = os_pad;
      end
      for (int i = 0; i < NCH; i++) begin
         if (adr == ADR_PER0 + 3'(i)) begin
            rdata_d = 16'(per_q[i]);
         end
      end
   end

   always_ff @(posedge clk5mhz) begin
      if (rst) begin
         pcnt_q  <= '0;
         t1us_q  <= 1'b0;
         os_q    <= '0;
         rdata_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            per_q[i] <= '0;
         end
      end else begin
         pcnt_q  <= pcnt_d;
         t1us_q  <= t1us_d;
         os_q    <= os_d;
         rdata_q <= rdata_d;
         for (int i = 0; i < NCH; i++) begin
            per_q[i] <= per_d[i];
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      us_timebase_chan #(.PW(PW)) u_chan (
         .clk_i   (clk5mhz),
         .rst_i   (rst),
         .per_i   (per_q[i]),
         .mode_i  (os_d[i]),
         .t1us_i  (t1us_q),
         .load_i  (per_wr[i] || sync),
         .en_wr_i (ctrl_wr),
         .en_i    (data[EN_LSB + i]),
         .pulse_o (ch_pulse[i]),
         .run_o   (ch_run[i])
      );
   end

   assign rdata = rdata_q;
   assign t1us  = t1us_q;
endmodule
